// File: rtl/spi_adc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_adc_pkg: shared state encoding and width helpers for spi_adc_master. Rev 1.0
// ----------------------------------------------------------------------------
package spi_adc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_QUIET = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int frame_bits(input int lead, input int data_w, input int trail);
    return lead + data_w + trail;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_sclk_gen: CLK_DIV divider for sclk with next-edge rise/fall strobes. Rev 1.0
// ----------------------------------------------------------------------------
module spi_sclk_gen
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DIV_W = clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             run_q;

  // Enabling with div_q at zero makes the very first enabled edge drive sclk low.
  always_comb begin
    div_d  = '0;
    sclk_d = 1'b1;
    if (en_i) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      sclk_d = (div_q == '0) ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
      run_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      run_q  <= en_i;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = run_q && !sclk_q && (div_q == '0);
  assign fall_o = run_q &&  sclk_q && (div_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_adc_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_adc_master: read-only SPI ADC master, optional SPI_LEAD_CHECK_EN. Rev 1.0
// ----------------------------------------------------------------------------
module spi_adc_master
  import spi_adc_pkg::*;
#(
  parameter int CLK_DIV    = 12,
  parameter int DATA_W     = 8,
  parameter int LEAD_BITS  = 3,
  parameter int TRAIL_BITS = 4,
  parameter int QUIET_CYC  = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic              sdata_i,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  frame_cnt_o
`ifdef SPI_LEAD_CHECK_EN
  ,
  output logic              lead_err_o
`endif
);

  localparam int FRAME_BITS = frame_bits(LEAD_BITS, DATA_W, TRAIL_BITS);
  localparam int BIT_W      = clog2(FRAME_BITS);
  localparam int CYC_W      = clog2((CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC);

  logic [1:0]        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;
  logic              w_rise, w_fall, w_done;
  int                w_k;
`ifdef SPI_LEAD_CHECK_EN
  logic              lead_flag_q, lead_flag_d;
  logic              lead_err_q, lead_err_d;
`endif

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_d == ST_SHIFT),
    .sclk_o (sclk_o),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  assign w_k    = int'(bit_q);
  assign w_done = (state_q == ST_SHIFT) && (state_d == ST_QUIET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        cyc_d = '0;
        if (start_i || cont_i) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (cyc_q == CYC_W'(CLK_DIV - 1)) begin
          state_d = ST_SHIFT;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // w_fall marks the last cycle of a slot's high half.
        if (w_fall) begin
          if (bit_q == BIT_W'(FRAME_BITS - 1)) state_d = ST_QUIET;
          else                                 bit_d   = bit_q + 1'b1;
        end
      end
      default: begin
        if (cyc_q == CYC_W'(QUIET_CYC - 1)) begin
          state_d = cont_i ? ST_SETUP : ST_IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    busy_d  = (state_d != ST_IDLE);
    dv_d    = w_done;
    data_d  = w_done ? shift_q : data_q;
    cnt_d   = w_done ? cnt_q + 1'b1 : cnt_q;
    shift_d = shift_q;
    if (w_rise && (w_k >= LEAD_BITS) && (w_k < LEAD_BITS + DATA_W))
      shift_d = {shift_q[DATA_W-2:0], sdata_i};
  end

`ifdef SPI_LEAD_CHECK_EN
  always_comb begin
    lead_flag_d = lead_flag_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) lead_flag_d = 1'b0;
    if (w_rise && (w_k < LEAD_BITS) && sdata_i)          lead_flag_d = 1'b1;
    lead_err_d = w_done ? lead_flag_q : lead_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lead_flag_q <= 1'b0;
      lead_err_q  <= 1'b0;
    end else begin
      lead_flag_q <= lead_flag_d;
      lead_err_q  <= lead_err_d;
    end
  end

  assign lead_err_o = lead_err_q;
`endif

  assign cs_n_o       = cs_n_q;
  assign busy_o       = busy_q;
  assign data_valid_o = dv_q;
  assign data_o       = data_q;
  assign frame_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_adc_master: scoreboard bench with an ADC serial model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_adc_master;

  localparam int CLK_DIV    = 2;
  localparam int DATA_W     = 8;
  localparam int LEAD_BITS  = 3;
  localparam int TRAIL_BITS = 4;
  localparam int QUIET_CYC  = 4;
  localparam int CNT_W      = 4;
  localparam int FRAME_BITS = LEAD_BITS + DATA_W + TRAIL_BITS;
  localparam int LATENCY    = 1 + CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
  localparam int PERIOD     = CLK_DIV + 2 * CLK_DIV * FRAME_BITS + QUIET_CYC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              sdata = 1'b0;
  logic              sclk, cs_n, busy, data_valid;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  frame_cnt;
`ifdef SPI_LEAD_CHECK_EN
  logic              lead_err;
`endif

  spi_adc_master #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .LEAD_BITS(LEAD_BITS),
    .TRAIL_BITS(TRAIL_BITS), .QUIET_CYC(QUIET_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .cont_i       (cont),
    .sdata_i      (sdata),
    .sclk_o       (sclk),
    .cs_n_o       (cs_n),
    .busy_o       (busy),
    .data_valid_o (data_valid),
    .data_o       (data),
    .frame_cnt_o  (frame_cnt)
`ifdef SPI_LEAD_CHECK_EN
    ,
    .lead_err_o   (lead_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              lead;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t                    sb_q[$];
  logic [FRAME_BITS-1:0]   adc_q[$];
  int                      dv_cyc_q[$];
  int                      vectors = 0;
  int                      miscompares = 0;
  int                      cyc = 0;
  int                      cs_low, rises, dv_cnt, hi_run, min_gap, t_start;
  bit                      seen_low, saw_wrap;
  logic                    sclk_prev = 1'b1;
  logic [CNT_W-1:0]        exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ADC model: frame bits leave MSB-first on each sclk falling edge.
  initial begin
    logic [FRAME_BITS-1:0] cur;
    forever begin
      @(negedge cs_n);
      cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
      for (int i = FRAME_BITS - 1; i >= 0; i--) begin
        @(negedge sclk or posedge cs_n);
        if (cs_n) break;
        sdata = cur[i];
      end
    end
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_cnt = '0;
    end else begin
      if (!cs_n) begin
        cs_low++;
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        seen_low = 1'b1;
        hi_run   = 0;
      end else begin
        hi_run++;
      end
      if (sclk && !sclk_prev) rises++;
      if (data_valid) begin
        exp_t e;
        dv_cnt++;
        dv_cyc_q.push_back(cyc);
        exp_cnt++;
        check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("data", 32'(data), 32'(e.data));
`ifdef SPI_LEAD_CHECK_EN
          check("lead_err", 32'(lead_err), 32'(e.lead));
`endif
        end
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        if (frame_cnt == '0) saw_wrap = 1'b1;
      end
    end
    sclk_prev = sclk;
  end

  task automatic push_frame(input logic [2:0] l, input logic [7:0] d, input logic [3:0] tr);
    exp_t e;
    adc_q.push_back({l, d, tr});
    e.lead = (l != 3'b000);
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic clear_stats();
    cs_low = 0; rises = 0; dv_cnt = 0; hi_run = 0; min_gap = 1000;
    seen_low = 1'b0; saw_wrap = 1'b0;
    dv_cyc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    t_start = cyc;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int n, input int budget);
    int k = 0;
    while (dv_cnt < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(dv_cnt >= n), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int n, input int budget);
    int k = 0;
    while (rises < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(rises >= n), 32'd1);
  endtask

  task automatic wait_cs_low(input string tag, input int budget);
    int k = 0;
    while (cs_n !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(cs_n), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  function automatic int dv_at(input int i);
    return (i < dv_cyc_q.size()) ? dv_cyc_q[i] : -100000;
  endfunction

  initial begin
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
`ifdef SPI_LEAD_CHECK_EN
    check("rst_lead_err", 32'(lead_err), 32'd0);
`endif
    rst = 1'b0;

    // Nominal single frame
    repeat (2) @(negedge clk);
    clear_stats();
    push_frame(3'b000, 8'hA5, 4'h0);
    pulse_start();
    wait_dv("nom_dv_timeout", 1, 200);
    wait_idle("nom_idle", 50);
    check("nom_latency", 32'(dv_at(0) - t_start), 32'(LATENCY));
    check("nom_rises", 32'(rises), 32'(FRAME_BITS));
    check("nom_cs_low", 32'(cs_low), 32'(LATENCY - 1));
    check("nom_dv_cnt", 32'(dv_cnt), 32'd1);
    check("nom_data", 32'(data), 32'hA5);
    check("nom_cnt", 32'(frame_cnt), 32'd1);

    // Start pulses while busy are ignored
    clear_stats();
    push_frame(3'b000, 8'h96, 4'hF);
    pulse_start();
    wait_rises("busy_shift", 5, 100);
    pulse_start();
    wait_dv("busy_dv_timeout", 1, 200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    check("busy_dv_cnt", 32'(dv_cnt), 32'd1);
    check("busy_cs_low", 32'(cs_low), 32'(LATENCY - 1));
    check("busy_idle", 32'(busy), 32'd0);

    // Continuous mode, cont dropped during the third frame
    clear_stats();
    push_frame(3'b000, 8'h01, 4'h5);
    push_frame(3'b000, 8'h80, 4'hA);
    push_frame(3'b000, 8'hFF, 4'h0);
    @(negedge clk);
    cont = 1'b1;
    wait_dv("cont_dv2_timeout", 2, 300);
    wait_cs_low("cont_frame3", 30);
    cont = 1'b0;
    wait_dv("cont_dv3_timeout", 3, 200);
    wait_idle("cont_idle", 50);
    repeat (20) @(negedge clk);
    check("cont_dv_cnt", 32'(dv_cnt), 32'd3);
    check("cont_period1", 32'(dv_at(1) - dv_at(0)), 32'(PERIOD));
    check("cont_period2", 32'(dv_at(2) - dv_at(1)), 32'(PERIOD));
    check("cont_quiet_gap", 32'(min_gap >= QUIET_CYC), 32'd1);
    check("cont_busy", 32'(busy), 32'd0);
    check("cont_cnt", 32'(frame_cnt), 32'd5);

    // Asynchronous reset during data bit 4
    clear_stats();
    push_frame(3'b000, 8'hC3, 4'h0);
    pulse_start();
    wait_rises("rst_bit4", LEAD_BITS + 5, 200);
    #1 rst = 1'b1;
    #1;
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_sclk", 32'(sclk), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(data), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("arst_no_valid", 32'(dv_cnt), 32'd0);
    clear_stats();
    push_frame(3'b000, 8'h5A, 4'hA);
    pulse_start();
    wait_dv("arst_dv_timeout", 1, 200);
    wait_idle("arst_idle", 50);
    check("arst_data2", 32'(data), 32'h5A);
    check("arst_cnt2", 32'(frame_cnt), 32'd1);

    // Seventeen continuous frames wrap the 4-bit counter
    clear_stats();
    for (int i = 0; i < 17; i++) push_frame(3'b000, 8'(i * 29 + 7), 4'(i));
    @(negedge clk);
    cont = 1'b1;
    wait_dv("wrap_dv16_timeout", 16, 17 * PERIOD + 100);
    wait_cs_low("wrap_frame17", 30);
    cont = 1'b0;
    wait_dv("wrap_dv17_timeout", 17, 200);
    wait_idle("wrap_idle", 50);
    check("wrap_dv_cnt", 32'(dv_cnt), 32'd17);
    check("wrap_seen", 32'(saw_wrap), 32'd1);
    check("wrap_cnt", 32'(frame_cnt), 32'd2);

    // Non-zero leading bits, then a clean frame
    clear_stats();
    push_frame(3'b010, 8'h3C, 4'h0);
    push_frame(3'b000, 8'hC3, 4'h0);
    pulse_start();
    wait_dv("lead_dv1_timeout", 1, 200);
    wait_idle("lead_idle1", 50);
    check("lead_data1", 32'(data), 32'h3C);
    pulse_start();
    wait_dv("lead_dv2_timeout", 2, 200);
    wait_idle("lead_idle2", 50);
    check("lead_data2", 32'(data), 32'hC3);
`ifdef SPI_LEAD_CHECK_EN
    check("lead_err_clear", 32'(lead_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_adc_master.md
Name: spi_adc_master

Overview:
Parametrised SPI master that reads serial ADCs with a read-only, clock-driven frame, e.g. ADCS7476/AD7476-class parts. Each conversion drives cs_n low, generates a divided sclk and skips LEAD_BITS leading bits. It then captures DATA_W bits MSB-first, clocks TRAIL_BITS trailing bits, and presents the word with a one-cycle valid strobe. It supports single-shot and continuous conversion, a guaranteed cs_n quiet time, and a frame counter. It sits between the ADC pins and the sample-processing logic.

Parameters:
CLK_DIV, 12, sclk half-period in clk cycles (>=2); the sclk period is 2*CLK_DIV.
DATA_W, 8, number of captured data bits.
LEAD_BITS, 3, bits clocked and discarded before data (>=0).
TRAIL_BITS, 4, bits clocked and discarded after data (>=0).
QUIET_CYC, 4, minimum clk cycles cs_n is held high between frames (>=1).
CNT_W, 16, frame counter width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  level; sampled in IDLE to begin one conversion.
cont  in  1  continuous mode; while high, a new frame starts automatically after QUIET.
sdata  in  1  ADC serial data (MISO).
sclk  out  1  serial clock; idles high.
cs_n  out  1  chip select, active low.
busy  out  1  high in any state other than IDLE.
data_valid  out  1  one-cycle pulse when data updates.
data  out  DATA_W  last completed sample.
frame_cnt  out  CNT_W  completed-frame count; wraps to 0 after 2^CNT_W-1.
lead_err  out  1  present only with the optional feature.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, cs_n=1, sclk=1, busy=0, data_valid=0, data=0, frame_cnt=0, lead_err=0.
  - The internal shift register and counters clear.
  - Assertion mid-frame aborts the frame: no data_valid, data keeps its reset value of 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE: cs_n=1, sclk=1. If start|cont is high, go to SETUP next cycle. start is ignored in every other state.
- SETUP: cs_n=0, sclk=1 for CLK_DIV cycles (tCSS), then go to SHIFT.
- SHIFT: FRAME_BITS = LEAD_BITS+DATA_W+TRAIL_BITS bit slots, each 2*CLK_DIV cycles.
  - Each slot: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The falling edge at slot start is the ADC's shift edge.
  - sdata is sampled on the clk edge that drives sclk 0->1.
  - Slot index k (0-based) is shifted into the shift register only for LEAD_BITS <= k < LEAD_BITS+DATA_W, MSB first.
  - After the high half of the last slot, go to QUIET.
- QUIET (entry cycle): cs_n=1, sclk=1, data <= shift register, data_valid=1 for exactly that cycle, frame_cnt <= frame_cnt+1 (modulo 2^CNT_W).
- QUIET: stay QUIET_CYC cycles, then:
  - if cont=1, go to SETUP;
  - else go to IDLE, where start is evaluated again.
- cont falling mid-frame: the current frame completes normally, then the block returns to IDLE.
- Latency: a start seen in IDLE at cycle t produces data_valid at t+1+CLK_DIV+2*CLK_DIV*FRAME_BITS.
- Continuous mode: frame-to-frame period = CLK_DIV+2*CLK_DIV*FRAME_BITS+QUIET_CYC cycles.
- Simultaneous start and cont in IDLE: one frame starts; continuous behaviour follows cont.
- data holds between valid strobes; partial shift contents are never visible on data.

Optional Feature:
SPI_LEAD_CHECK_EN.
- Defined:
  - port lead_err exists;
  - any leading-bit sample equal to 1 sets a sticky per-frame flag;
  - lead_err is loaded with that flag on the data_valid cycle and holds until the next data_valid;
  - lead_err reset value is 0.
- Not defined: port and logic are absent; leading bits are discarded unchecked.

Decomposition:
- Package spi_adc_pkg:
  - state encoding constants ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET;
  - a clog2 function for counter widths;
  - FRAME_BITS derivation.
- Sub-module spi_sclk_gen: CLK_DIV divider producing sclk plus one-cycle rise/fall strobes, with an enable input. The FSM and shift/capture logic stay in the top level.

Test Plan:
- Nominal frame (CLK_DIV=2, DATA_W=8, LEAD=3, TRAIL=4): ADC model sends 000 + 0xA5 + 0000; pulse start one cycle.
  - Required: exactly 15 sclk rising edges; cs_n low 62 cycles; data=0xA5; one data_valid pulse 63 cycles after start is sampled; frame_cnt=1.
- Continuous mode: cont=1 with words 0x01, 0x80, 0xFF, then cont=0 during frame 3.
  - Required: three data_valid pulses spaced 66 cycles apart with those values; cs_n high >=4 cycles between frames; return to IDLE; frame_cnt=3.
- Reset mid-frame: assert rst during data bit 4.
  - Required: cs_n=1 and sclk=1 without waiting for a clk edge; data=0; no data_valid; after release, a new start yields a correct frame.
- Start while busy: extra start pulses during SHIFT and QUIET (cont=0).
  - Required: ignored; exactly one frame.
- Counter wrap: CNT_W=4, 17 continuous frames.
  - Required: frame_cnt sequence ..., 15, 0, 1.
- SPI_LEAD_CHECK_EN defined: lead bits 010 with data 0x3C.
  - Required: data=0x3C and lead_err=1 on valid; next frame with lead bits 000 gives lead_err=0.
